// File: rtl/bp_read_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_read_port_arbiter_pkg
//  Description : Shared types for the BP backup file / PC file read-port
//                arbiter: fetch ID, update payload and read-owner tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_read_port_arbiter_pkg;

    localparam int BP_FID_W = 5;
    localparam int BP_UPD_W = 16;

    typedef logic [BP_FID_W-1:0] FetchID_t;
    typedef logic [BP_UPD_W-1:0] BPUpdate;

    // Which consumer owns the read data returning one cycle after a grant
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_REC  = 2'd1,
        RD_UPD  = 2'd2
    } ReadOwner;

endpackage
`default_nettype wire

// File: rtl/bp_read_port_arbiter_update_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : update_fifo
//  Description : Small in-order buffer for committed branch updates with head
//                peek, enqueue/dequeue, occupancy count and full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module update_fifo
    import bp_read_port_arbiter_pkg::*;
#(
    parameter int WIDTH = BP_FID_W + BP_UPD_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       deq,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;

    assign head  = mem[rd_ptr];
    assign count = occ;
    assign full  = (occ == DEPTH_CNT);
    assign empty = (occ == '0);

    // Storage array: written at the tail, contents are don't-care until valid
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_read_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_read_port_arbiter
//  Description : Arbitrates the shared BP backup file / PC file read port
//                between mispredict recovery (always wins) and buffered
//                committed branch updates. Tags returning read data with its
//                owner, drives the fetch limit and a starvation status flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_read_port_arbiter
    import bp_read_port_arbiter_pkg::*;
#(
    parameter int FID_W    = BP_FID_W,
    parameter int UPD_W    = BP_UPD_W,
    parameter int DEPTH    = 4,
    parameter int STARVE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_misprValid,
    input  logic [FID_W-1:0]  IN_misprFetchID,
    input  logic              IN_misprNeedPC,
    input  logic              IN_updValid,
    input  logic [FID_W-1:0]  IN_updFetchID,
    input  logic [UPD_W-1:0]  IN_updData,
    output logic              OUT_updReady,
    output logic              OUT_bpFileRE,
    output logic [FID_W-1:0]  OUT_bpFileRAddr,
    output logic              OUT_pcFileRE,
    output logic [FID_W-1:0]  OUT_pcFileRAddr,
    output logic              OUT_recValid,
    output logic [FID_W-1:0]  OUT_recFetchID,
    output logic              OUT_updActValid,
    output logic [FID_W-1:0]  OUT_updActFetchID,
    output logic [UPD_W-1:0]  OUT_updActData,
    output logic              OUT_limitValid,
    output logic [FID_W-1:0]  OUT_limitFetchID,
    output logic              OUT_starved
);

    localparam int ENT_W = FID_W + UPD_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ENT_W-1:0]    fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FID_W-1:0]    head_id;
    logic [UPD_W-1:0]    head_data;

    ReadOwner            owner;
    logic                bp_re;
    logic                pc_re;
    logic [FID_W-1:0]    grant_id;
    logic [UPD_W-1:0]    grant_data;
    logic                deq;
    logic                bypass;
    logic                accept;
    logic                enq;

    logic [STARVE_W-1:0] starve_cnt;

    assign head_id   = fifo_head[ENT_W-1:UPD_W];
    assign head_data = fifo_head[UPD_W-1:0];

    update_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_update_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_data ({IN_updFetchID, IN_updData}),
        .deq      (deq),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Port grant: recovery first, then queued head, then same-cycle bypass
    always_comb begin
        owner      = RD_NONE;
        bp_re      = 1'b0;
        pc_re      = 1'b0;
        grant_id   = IN_misprFetchID;
        grant_data = IN_updData;
        deq        = 1'b0;
        bypass     = 1'b0;
        if (IN_misprValid) begin
            owner    = RD_REC;
            bp_re    = 1'b1;
            pc_re    = IN_misprNeedPC;
            grant_id = IN_misprFetchID;
        end else if (!fifo_empty) begin
            owner      = RD_UPD;
            bp_re      = 1'b1;
            pc_re      = 1'b1;
            grant_id   = head_id;
            grant_data = head_data;
            deq        = 1'b1;
        end else if (IN_updValid) begin
            // Only reachable with an empty queue, so ordering is preserved
            owner      = RD_UPD;
            bp_re      = 1'b1;
            pc_re      = 1'b1;
            grant_id   = IN_updFetchID;
            grant_data = IN_updData;
            bypass     = 1'b1;
        end
    end

    // Readiness uses the pre-dequeue occupancy, so a full queue stays closed
    // for the cycle in which its head drains
    assign OUT_updReady = !fifo_full;
    assign accept       = IN_updValid && !fifo_full;
    assign enq          = accept && !bypass;

    assign OUT_bpFileRE    = bp_re;
    assign OUT_bpFileRAddr = grant_id;
    assign OUT_pcFileRE    = pc_re;
    assign OUT_pcFileRAddr = grant_id;

    // Fetch must not overwrite the oldest entry still waiting for its read
    assign OUT_limitValid   = (fifo_count != '0) || IN_updValid;
    assign OUT_limitFetchID = (fifo_count != '0) ? head_id : IN_updFetchID;

    // Tag the data returning next cycle with the consumer that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_recValid      <= 1'b0;
            OUT_recFetchID    <= '0;
            OUT_updActValid   <= 1'b0;
            OUT_updActFetchID <= '0;
            OUT_updActData    <= '0;
        end else begin
            OUT_recValid      <= (owner == RD_REC);
            OUT_recFetchID    <= grant_id;
            OUT_updActValid   <= (owner == RD_UPD);
            OUT_updActFetchID <= grant_id;
            OUT_updActData    <= grant_data;
        end
    end

    // Count cycles where recovery holds the port while updates wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (owner == RD_UPD) begin
            starve_cnt <= '0;
        end else if (IN_misprValid && !fifo_empty && !(&starve_cnt)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign OUT_starved = &starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bp_read_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_read_port_arbiter
//  Description : Self-checking bench for bp_read_port_arbiter with a
//                reference queue model and a scoreboard of expected
//                registered read-owner results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_read_port_arbiter;
    import bp_read_port_arbiter_pkg::*;

    localparam int FID_W    = 5;
    localparam int UPD_W    = 16;
    localparam int DEPTH    = 4;
    localparam int STARVE_W = 4;
    localparam int SAT      = (1 << STARVE_W) - 1;

    logic              clk;
    logic              rst;
    logic              IN_misprValid;
    logic [FID_W-1:0]  IN_misprFetchID;
    logic              IN_misprNeedPC;
    logic              IN_updValid;
    logic [FID_W-1:0]  IN_updFetchID;
    logic [UPD_W-1:0]  IN_updData;
    logic              OUT_updReady;
    logic              OUT_bpFileRE;
    logic [FID_W-1:0]  OUT_bpFileRAddr;
    logic              OUT_pcFileRE;
    logic [FID_W-1:0]  OUT_pcFileRAddr;
    logic              OUT_recValid;
    logic [FID_W-1:0]  OUT_recFetchID;
    logic              OUT_updActValid;
    logic [FID_W-1:0]  OUT_updActFetchID;
    logic [UPD_W-1:0]  OUT_updActData;
    logic              OUT_limitValid;
    logic [FID_W-1:0]  OUT_limitFetchID;
    logic              OUT_starved;

    bp_read_port_arbiter #(
        .FID_W    (FID_W),
        .UPD_W    (UPD_W),
        .DEPTH    (DEPTH),
        .STARVE_W (STARVE_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .IN_misprValid     (IN_misprValid),
        .IN_misprFetchID   (IN_misprFetchID),
        .IN_misprNeedPC    (IN_misprNeedPC),
        .IN_updValid       (IN_updValid),
        .IN_updFetchID     (IN_updFetchID),
        .IN_updData        (IN_updData),
        .OUT_updReady      (OUT_updReady),
        .OUT_bpFileRE      (OUT_bpFileRE),
        .OUT_bpFileRAddr   (OUT_bpFileRAddr),
        .OUT_pcFileRE      (OUT_pcFileRE),
        .OUT_pcFileRAddr   (OUT_pcFileRAddr),
        .OUT_recValid      (OUT_recValid),
        .OUT_recFetchID    (OUT_recFetchID),
        .OUT_updActValid   (OUT_updActValid),
        .OUT_updActFetchID (OUT_updActFetchID),
        .OUT_updActData    (OUT_updActData),
        .OUT_limitValid    (OUT_limitValid),
        .OUT_limitFetchID  (OUT_limitFetchID),
        .OUT_starved       (OUT_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FID_W-1:0] id;
        logic [UPD_W-1:0] data;
    } upd_t;

    typedef struct {
        int               kind;   // 0 none, 1 recovery, 2 update
        logic [FID_W-1:0] id;
        logic [UPD_W-1:0] data;
    } exp_t;

    upd_t mq[$];     // model of queued updates
    upd_t pend[$];   // updates the bench still has to offer
    exp_t sb[$];     // expected registered results
    int   seen[$];   // update IDs the DUT actually returned
    int   starve;
    int   n_cmp;
    int   n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare registered owner outputs against the oldest scoreboard entry
    task automatic check_reg();
        exp_t e;
        if (OUT_updActValid === 1'b1) seen.push_back(int'(OUT_updActFetchID));
        if (sb.size() == 0) begin
            check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("recValid", 32'(OUT_recValid), 32'(e.kind == 1));
        if (e.kind == 1) check_eq("recFetchID", 32'(OUT_recFetchID), 32'(e.id));
        check_eq("updActValid", 32'(OUT_updActValid), 32'(e.kind == 2));
        if (e.kind == 2) begin
            check_eq("updActFetchID", 32'(OUT_updActFetchID), 32'(e.id));
            check_eq("updActData", 32'(OUT_updActData), 32'(e.data));
        end
    endtask

    // One clock of stimulus: check last cycle's registered result, drive,
    // check combinational outputs against the model, then advance the model
    task automatic step(input logic mv, input logic [FID_W-1:0] mid, input logic npc);
        upd_t u;
        exp_t e;
        logic uv, empty, full, ebp, epc, lv, acc, byp;
        logic [FID_W-1:0] eaddr, lid;
        @(negedge clk);
        check_reg();
        uv = (pend.size() != 0);
        u.id = '0;
        u.data = '0;
        if (uv) u = pend[0];
        IN_misprValid   = mv;
        IN_misprFetchID = mid;
        IN_misprNeedPC  = npc;
        IN_updValid     = uv;
        IN_updFetchID   = u.id;
        IN_updData      = u.data;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        e.kind = 0; e.id = '0; e.data = '0;
        ebp = 1'b0; epc = 1'b0; eaddr = '0;
        if (mv) begin
            e.kind = 1; e.id = mid; ebp = 1'b1; epc = npc; eaddr = mid;
        end else if (!empty) begin
            e.kind = 2; e.id = mq[0].id; e.data = mq[0].data;
            ebp = 1'b1; epc = 1'b1; eaddr = mq[0].id;
        end else if (uv) begin
            e.kind = 2; e.id = u.id; e.data = u.data;
            ebp = 1'b1; epc = 1'b1; eaddr = u.id;
        end
        check_eq("bpFileRE", 32'(OUT_bpFileRE), 32'(ebp));
        if (ebp) check_eq("bpFileRAddr", 32'(OUT_bpFileRAddr), 32'(eaddr));
        check_eq("pcFileRE", 32'(OUT_pcFileRE), 32'(epc));
        if (epc) check_eq("pcFileRAddr", 32'(OUT_pcFileRAddr), 32'(eaddr));
        check_eq("updReady", 32'(OUT_updReady), 32'(!full));
        lv  = !empty || uv;
        lid = !empty ? mq[0].id : u.id;
        check_eq("limitValid", 32'(OUT_limitValid), 32'(lv));
        if (lv) check_eq("limitFetchID", 32'(OUT_limitFetchID), 32'(lid));
        check_eq("starved", 32'(OUT_starved), 32'(starve == SAT));
        acc = uv && !full;
        byp = uv && empty && !mv;
        if (e.kind == 2) starve = 0;
        else if (mv && !empty && starve < SAT) starve++;
        if (!mv && !empty) void'(mq.pop_front());
        if (acc && !byp) mq.push_back(u);
        if (acc) void'(pend.pop_front());
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        IN_misprValid   = 1'b0;
        IN_misprFetchID = '0;
        IN_misprNeedPC  = 1'b0;
        IN_updValid     = 1'b0;
        IN_updFetchID   = '0;
        IN_updData      = '0;
    endtask

    // Asynchronous reset: registered owners must drop without a clock edge
    task automatic apply_reset();
        exp_t e;
        @(negedge clk);
        #2;
        idle_inputs();
        rst = 1'b0;
        #1;
        check_eq("rst_recValid", 32'(OUT_recValid), 32'd0);
        check_eq("rst_updActValid", 32'(OUT_updActValid), 32'd0);
        check_eq("rst_updReady", 32'(OUT_updReady), 32'd1);
        check_eq("rst_limitValid", 32'(OUT_limitValid), 32'd0);
        check_eq("rst_bpFileRE", 32'(OUT_bpFileRE), 32'd0);
        check_eq("rst_starved", 32'(OUT_starved), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        pend.delete();
        sb.delete();
        starve = 0;
        e.kind = 0; e.id = '0; e.data = '0;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((pend.size() != 0 || mq.size() != 0) && n < budget) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        if (n >= budget) check_eq({tag, "_timeout"}, 32'(n), 32'(budget - 1));
        repeat (2) step(1'b0, '0, 1'b0);
    endtask

    task automatic check_seen(input string tag, input int exp_ids[$]);
        check_eq({tag, "_count"}, 32'(seen.size()), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < seen.size(); i++) begin
            check_eq({tag, "_order"}, 32'(seen[i]), 32'(exp_ids[i]));
        end
    endtask

    task automatic push_upd(input int id);
        upd_t u;
        u.id   = FID_W'(id);
        u.data = UPD_W'($urandom_range(0, 65535));
        pend.push_back(u);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        starve = 0;
        rst    = 1'b1;
        idle_inputs();

        // Power-on reset, then idle
        apply_reset();
        repeat (3) step(1'b0, '0, 1'b0);

        // Lone update on an empty queue bypasses straight to the port
        seen.delete();
        push_upd(7);
        step(1'b0, '0, 1'b0);
        drain("bypass", 10);
        check_seen("bypass", '{7});

        // Mispredict beats a simultaneous update, which then queues
        seen.delete();
        push_upd(9);
        step(1'b1, 5'd3, 1'b0);
        drain("mispr", 10);
        check_seen("mispr", '{9});

        // Sustained recovery: queue fills, starvation saturates, then drain in order
        seen.delete();
        for (int i = 1; i <= 5; i++) push_upd(i);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, FID_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        check_eq("starved_sat", 32'(OUT_starved), 32'd1);
        check_eq("full_not_ready", 32'(OUT_updReady), 32'd0);
        drain("starve", 30);
        check_seen("starve", '{1, 2, 3, 4, 5});

        // Pointer wrap with sporadic recovery pulses
        seen.delete();
        for (int i = 0; i < 10; i++) push_upd(i);
        for (int c = 0; c < 200 && (pend.size() != 0 || mq.size() != 0); c++) begin
            step(($urandom_range(0, 2) == 0), FID_W'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
        end
        drain("wrap", 40);
        check_seen("wrap", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});

        // Reset with three entries queued and recovery data in flight
        for (int i = 20; i < 23; i++) push_upd(i);
        repeat (3) step(1'b1, 5'd11, 1'b1);
        apply_reset();
        repeat (2) step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
